// File: rtl/cdb_arbiter_if.sv
// Bundle of the FU-side result handshake and the CDB broadcast lanes.
// master: the arbiter (drives fu_ready and the CDB lanes).
// slave:  the FU pipelines / CDB consumers seen from the other side.
interface cdb_arbiter_if #(
  parameter int FU_NUM     = 4,
  parameter int CDB_WIDTH  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic [FU_NUM-1:0]               fu_valid;
  logic [FU_NUM-1:0]               fu_ready;
  logic [FU_NUM*TAG_WIDTH-1:0]     fu_tag;
  logic [FU_NUM*DATA_WIDTH-1:0]    fu_data;
  logic [CDB_WIDTH-1:0]            cdb_valid;
  logic [CDB_WIDTH*TAG_WIDTH-1:0]  cdb_tag;
  logic [CDB_WIDTH*DATA_WIDTH-1:0] cdb_data;

  modport master (
    input  fu_valid, fu_tag, fu_data,
    output fu_ready, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    output fu_valid, fu_tag, fu_data,
    input  fu_ready, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus producer: one-entry result hold per FU, round-robin grant
// of up to CDB_WIDTH holds per cycle onto registered CDB lanes.
// Optional macro CDB_BYPASS_EN: a handshaking FU with an empty hold may take
// a lane left free by held grants in the same edge, skipping its hold.
module cdb_arbiter #(
  parameter int FU_NUM     = 4,
  parameter int CDB_WIDTH  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.master bus
);
  localparam int PTR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  logic [FU_NUM-1:0]     hold_valid;
  logic [TAG_WIDTH-1:0]  hold_tag  [FU_NUM];
  logic [DATA_WIDTH-1:0] hold_data [FU_NUM];
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_next;

  logic [FU_NUM-1:0]     grant;
  logic                  any_grant;
  logic [FU_NUM-1:0]     ready;
  logic [FU_NUM-1:0]     accept;
  logic [FU_NUM-1:0]     bypass;
  logic [FU_NUM-1:0]     load_hold;

  logic [CDB_WIDTH-1:0]  held_use;
  logic [TAG_WIDTH-1:0]  held_tag  [CDB_WIDTH];
  logic [DATA_WIDTH-1:0] held_data [CDB_WIDTH];
  logic [CDB_WIDTH-1:0]  lane_use;
  logic [TAG_WIDTH-1:0]  lane_tag  [CDB_WIDTH];
  logic [DATA_WIDTH-1:0] lane_data [CDB_WIDTH];

  logic [CDB_WIDTH-1:0]            cdb_valid_q;
  logic [CDB_WIDTH*TAG_WIDTH-1:0]  cdb_tag_q;
  logic [CDB_WIDTH*DATA_WIDTH-1:0] cdb_data_q;

  // Ready depends only on registered state and flush; held low during reset.
  assign ready        = rst ? ((~hold_valid | grant) & {FU_NUM{~flush}}) : '0;
  assign accept       = bus.fu_valid & ready;
  assign load_hold    = accept & ~bypass;
  assign bus.fu_ready = ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;

  // Round-robin scan: rank each valid hold by its distance from rr_ptr and
  // grant the first CDB_WIDTH of them; lane k carries rank k.
  always_comb begin : grant_scan
    int pos  [FU_NUM];
    int rank [FU_NUM];
    int best;
    for (int j = 0; j < FU_NUM; j++) begin
      pos[j] = j - int'(rr_ptr);
      if (pos[j] < 0) pos[j] = pos[j] + FU_NUM;
    end
    for (int j = 0; j < FU_NUM; j++) begin
      rank[j] = 0;
      for (int m = 0; m < FU_NUM; m++) begin
        if (hold_valid[m] && (pos[m] < pos[j])) rank[j] = rank[j] + 1;
      end
    end
    grant     = '0;
    any_grant = 1'b0;
    rr_next   = rr_ptr;
    best      = -1;
    for (int j = 0; j < FU_NUM; j++) begin
      if (hold_valid[j] && (rank[j] < CDB_WIDTH)) begin
        grant[j]  = 1'b1;
        any_grant = 1'b1;
        if (pos[j] > best) begin
          best    = pos[j];
          rr_next = PTR_W'((j + 1) % FU_NUM);
        end
      end
    end
    for (int k = 0; k < CDB_WIDTH; k++) begin
      held_use[k]  = 1'b0;
      held_tag[k]  = '0;
      held_data[k] = '0;
      for (int j = 0; j < FU_NUM; j++) begin
        if (grant[j] && (rank[j] == k)) begin
          held_use[k]  = 1'b1;
          held_tag[k]  = hold_tag[j];
          held_data[k] = hold_data[j];
        end
      end
    end
  end

  // Final lane contents: held grants first, then (optionally) bypassed results.
  always_comb begin : lane_merge
`ifdef CDB_BYPASS_EN
    int slot;
`endif
    lane_use  = held_use;
    lane_tag  = held_tag;
    lane_data = held_data;
    bypass    = '0;
`ifdef CDB_BYPASS_EN
    slot = $countones(grant);
    for (int j = 0; j < FU_NUM; j++) begin
      if (accept[j] && !hold_valid[j] && (slot < CDB_WIDTH)) begin
        bypass[j] = 1'b1;
        for (int k = 0; k < CDB_WIDTH; k++) begin
          if (k == slot) begin
            lane_use[k]  = 1'b1;
            lane_tag[k]  = bus.fu_tag[j*TAG_WIDTH +: TAG_WIDTH];
            lane_data[k] = bus.fu_data[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        slot = slot + 1;
      end
    end
`endif
  end

  // Hold occupancy: a new accept wins over the clear caused by a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       hold_valid <= '0;
    else if (flush) hold_valid <= '0;
    else            hold_valid <= load_hold | (hold_valid & ~grant);
  end

  // Hold payload is only meaningful while hold_valid is set, so no reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < FU_NUM; j++) begin
      if (load_hold[j]) begin
        hold_tag[j]  <= bus.fu_tag[j*TAG_WIDTH +: TAG_WIDTH];
        hold_data[j] <= bus.fu_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Registered CDB lanes; unused lanes keep their stale payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else if (flush) begin
      cdb_valid_q <= '0;
    end else begin
      cdb_valid_q <= lane_use;
      for (int k = 0; k < CDB_WIDTH; k++) begin
        if (lane_use[k]) begin
          cdb_tag_q[k*TAG_WIDTH +: TAG_WIDTH]    <= lane_tag[k];
          cdb_data_q[k*DATA_WIDTH +: DATA_WIDTH] <= lane_data[k];
        end
      end
    end
  end

  // Round-robin pointer advances past the last held grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rr_ptr <= '0;
    else if (flush)     rr_ptr <= '0;
    else if (any_grant) rr_ptr <= rr_next;
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: u0 uses CDB_WIDTH=2, u1 uses CDB_WIDTH=1.
// Build with CDB_BYPASS_EN to run the bypass sequence instead of the default one.
module tb_cdb_arbiter;
  logic clk;
  logic rst;
  logic flush;
  int   total;
  int   bad;

  cdb_arbiter_if #(.FU_NUM(4), .CDB_WIDTH(2), .DATA_WIDTH(32), .TAG_WIDTH(4)) bus0 ();
  cdb_arbiter_if #(.FU_NUM(4), .CDB_WIDTH(1), .DATA_WIDTH(32), .TAG_WIDTH(4)) bus1 ();

  cdb_arbiter #(.FU_NUM(4), .CDB_WIDTH(2), .DATA_WIDTH(32), .TAG_WIDTH(4)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0.master)
  );
  cdb_arbiter #(.FU_NUM(4), .CDB_WIDTH(1), .DATA_WIDTH(32), .TAG_WIDTH(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    flush = 1'b0;
    bus0.fu_valid = '0; bus0.fu_tag = '0; bus0.fu_data = '0;
    bus1.fu_valid = '0; bus1.fu_tag = '0; bus1.fu_data = '0;

    // reset asserted with all FUs requesting
    #2;
    rst = 1'b0;
    bus0.fu_valid = 4'b1111;
    bus1.fu_valid = 4'b1111;
    tick();
    tick();
    check("rst_ready0", 64'(bus0.fu_ready), 64'(4'b0000));
    check("rst_ready1", 64'(bus1.fu_ready), 64'(4'b0000));
    check("rst_cdb_valid", 64'(bus0.cdb_valid), 64'(2'b00));
    check("rst_cdb_tag", 64'(bus0.cdb_tag), 64'(8'h00));
    check("rst_rr_ptr", 64'(u0.rr_ptr), 64'(0));
    bus0.fu_valid = '0;
    bus1.fu_valid = '0;
    rst = 1'b1;
    #1;
    check("rel_ready", 64'(bus0.fu_ready), 64'(4'b1111));

`ifndef CDB_BYPASS_EN
    // contention: four results at once, two lanes
    bus0.fu_valid = 4'b1111;
    bus0.fu_tag   = 16'h4321;
    bus0.fu_data  = {32'h104, 32'h103, 32'h102, 32'h101};
    tick();
    bus0.fu_valid = '0;
    check("cont_ready_a", 64'(bus0.fu_ready), 64'(4'b0011));
    check("cont_valid_a", 64'(bus0.cdb_valid), 64'(2'b00));
    tick();
    check("cont_valid_b", 64'(bus0.cdb_valid), 64'(2'b11));
    check("cont_tag_b", 64'(bus0.cdb_tag), 64'(8'h21));
    check("cont_data_b", 64'(bus0.cdb_data), 64'h00000102_00000101);
    check("cont_ready_b", 64'(bus0.fu_ready), 64'(4'b1111));
    check("cont_ptr_b", 64'(u0.rr_ptr), 64'(2));
    tick();
    check("cont_valid_c", 64'(bus0.cdb_valid), 64'(2'b11));
    check("cont_tag_c", 64'(bus0.cdb_tag), 64'(8'h43));
    check("cont_data_c", 64'(bus0.cdb_data), 64'h00000104_00000103);
    check("cont_ptr_c", 64'(u0.rr_ptr), 64'(0));
    tick();
    check("cont_valid_d", 64'(bus0.cdb_valid), 64'(2'b00));

    // single result on FU2
    bus0.fu_valid = 4'b0100;
    bus0.fu_tag   = 16'h0500;
    bus0.fu_data  = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    tick();
    bus0.fu_valid = '0;
    check("single_valid_0", 64'(bus0.cdb_valid), 64'(2'b00));
    tick();
    check("single_valid_1", 64'(bus0.cdb_valid), 64'(2'b01));
    check("single_tag", 64'(bus0.cdb_tag[3:0]), 64'(4'h5));
    check("single_data", 64'(bus0.cdb_data[31:0]), 64'(32'hDEADBEEF));
    check("single_ptr", 64'(u0.rr_ptr), 64'(3));
    tick();
    check("single_valid_2", 64'(bus0.cdb_valid), 64'(2'b00));

    // flush with holds pending on FU1 and FU3
    bus0.fu_valid = 4'b1010;
    bus0.fu_tag   = 16'hA090;
    tick();
    check("flush_holds", 64'(u0.hold_valid), 64'(4'b1010));
    bus0.fu_valid = 4'b0001;
    bus0.fu_tag   = 16'h000C;
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(bus0.fu_ready), 64'(4'b0000));
    tick();
    flush = 1'b0;
    bus0.fu_valid = '0;
    check("flush_valid", 64'(bus0.cdb_valid), 64'(2'b00));
    check("flush_hold_clr", 64'(u0.hold_valid), 64'(4'b0000));
    check("flush_ptr", 64'(u0.rr_ptr), 64'(0));
    tick();
    check("flush_no_stale", 64'(bus0.cdb_valid), 64'(2'b00));

    // asynchronous reset in the middle of traffic
    bus0.fu_valid = 4'b0111;
    bus0.fu_tag   = 16'h0321;
    tick();
    bus0.fu_valid = '0;
    tick();
    check("mid_valid", 64'(bus0.cdb_valid), 64'(2'b11));
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus0.cdb_valid), 64'(2'b00));
    check("mid_rst_ready", 64'(bus0.fu_ready), 64'(4'b0000));
    check("mid_rst_hold", 64'(u0.hold_valid), 64'(4'b0000));
    tick();
    rst = 1'b1;
    tick();
    check("mid_after_valid", 64'(bus0.cdb_valid), 64'(2'b00));
    check("mid_after_ready", 64'(bus0.fu_ready), 64'(4'b1111));

    // fairness on the single-lane instance: FU0 and FU3 stream continuously
    bus1.fu_valid = 4'b1001;
    bus1.fu_tag   = 16'hB008;
    tick();
    check("fair_valid_0", 64'(bus1.cdb_valid), 64'(1'b0));
    check("fair_ready_0", 64'(bus1.fu_ready), 64'(4'b0111));
    for (int n = 0; n < 4; n++) begin
      tick();
      check("fair_valid", 64'(bus1.cdb_valid), 64'(1'b1));
      check("fair_tag", 64'(bus1.cdb_tag), (n % 2 == 0) ? 64'h8 : 64'hB);
    end
    bus1.fu_valid = '0;
`else
    // bypass: empty holds, FU1 goes straight to lane0
    bus0.fu_valid = 4'b0010;
    bus0.fu_tag   = 16'h0070;
    tick();
    bus0.fu_valid = '0;
    check("byp_valid", 64'(bus0.cdb_valid), 64'(2'b01));
    check("byp_tag", 64'(bus0.cdb_tag[3:0]), 64'(4'h7));
    check("byp_hold", 64'(u0.hold_valid), 64'(4'b0000));
    check("byp_ptr", 64'(u0.rr_ptr), 64'(0));
    tick();
    check("byp_valid_off", 64'(bus0.cdb_valid), 64'(2'b00));

    // four at once: FU0/FU1 bypass, FU2/FU3 held
    bus0.fu_valid = 4'b1111;
    bus0.fu_tag   = 16'h4321;
    tick();
    check("byp4_valid", 64'(bus0.cdb_valid), 64'(2'b11));
    check("byp4_tag", 64'(bus0.cdb_tag), 64'(8'h21));
    check("byp4_hold", 64'(u0.hold_valid), 64'(4'b1100));
    // two holds pending: the new FU0 result must be held
    bus0.fu_valid = 4'b0001;
    bus0.fu_tag   = 16'h0009;
    tick();
    bus0.fu_valid = '0;
    check("held_valid", 64'(bus0.cdb_valid), 64'(2'b11));
    check("held_tag", 64'(bus0.cdb_tag), 64'(8'h43));
    check("held_hold", 64'(u0.hold_valid), 64'(4'b0001));
    check("held_ptr", 64'(u0.rr_ptr), 64'(0));
    tick();
    check("held_out_valid", 64'(bus0.cdb_valid), 64'(2'b01));
    check("held_out_tag", 64'(bus0.cdb_tag[3:0]), 64'(4'h9));
    check("held_out_ptr", 64'(u0.rr_ptr), 64'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
